// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared types, encodings and decode helpers for the AHB-Lite to APB4 bridge
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    function automatic logic [3:0] slot_of(input logic [31:0] addr);
        return addr[15:12];
    endfunction

    function automatic logic [3:0] strb_of(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] strb;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr;
            HSIZE_HALF: strb = 4'b0011 << {addr[1], 1'b0};
            HSIZE_WORD: strb = 4'b1111;
            default:    strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - counts ACCESS cycles and flags the last one allowed before abort
module apb_timeout_counter #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_ports;
            assign unused_ports = ^{clk, rst_n, clear, enable};
            assign expired      = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(TIMEOUT + 1);
            logic [W-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // cnt is 0 in the first ACCESS cycle, so this fires on ACCESS cycle number TIMEOUT
            assign expired = enable && (cnt == W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/ahb_apb_bridge.sv
// rtl/ahb_apb_bridge.sv - single-slave AHB-Lite to APB4 bridge decoding up to 16 peripherals in 64 KB
module ahb_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int APB_SLAVES = 16,
    parameter int TIMEOUT    = 256
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       HSEL,
    input  logic [1:0]                 HTRANS,
    input  logic                       HWRITE,
    input  logic [2:0]                 HSIZE,
    input  logic [3:0]                 HPROT,
    input  logic [31:0]                HADDR,
    input  logic [31:0]                HWDATA,
    input  logic                       HREADY,
    output logic                       HREADYOUT,
    output logic                       HRESP,
    output logic [31:0]                HRDATA,
    output logic [APB_SLAVES-1:0]      PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [15:0]                PADDR,
    output logic [31:0]                PWDATA,
    output logic [3:0]                 PSTRB,
    output logic [2:0]                 PPROT,
    input  logic [32*APB_SLAVES-1:0]   PRDATA,
    input  logic [APB_SLAVES-1:0]      PREADY,
    input  logic [APB_SLAVES-1:0]      PSLVERR
);

    state_t                  state;
    state_t                  next_state;
    logic                    can_accept;
    logic                    accept;
    logic [3:0]              slot;
    logic                    mapped;
    logic [APB_SLAVES-1:0]   psel_d;
    logic [31:0]             sel_rdata;
    logic                    sel_ready;
    logic                    sel_err;
    logic                    expired;
    logic                    unused_inputs;

    assign unused_inputs = ^{HADDR[31:16], HPROT[3:2]};

    assign can_accept = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
    assign accept     = can_accept && HSEL && HREADY &&
                        ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign slot       = slot_of(HADDR);
    assign mapped     = ({1'b0, slot} < 5'(APB_SLAVES)) && (HSIZE <= HSIZE_WORD);

    always_comb begin
        psel_d = '0;
        for (int i = 0; i < APB_SLAVES; i++) begin
            psel_d[i] = (slot == 4'(i));
        end
    end

    // PSEL is one-hot during SETUP/ACCESS, so it doubles as the response mux select
    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < APB_SLAVES; i++) begin
            if (PSEL[i]) begin
                sel_rdata = PRDATA[i*32 +: 32];
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (accept) next_state = mapped ? ST_SETUP : ST_ERR1;
                else        next_state = ST_IDLE;
            end
            ST_SETUP:  next_state = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready)    next_state = sel_err ? ST_ERR1 : ST_DONE;
                else if (expired) next_state = ST_ERR1;
            end
            ST_ERR1:   next_state = ST_ERR2;
            default:   next_state = ST_IDLE;
        endcase
    end

    apb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .clear   (state != ST_ACCESS),
        .enable  (state == ST_ACCESS),
        .expired (expired)
    );

    // Outputs are registered from next_state so they line up with the state they describe
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PSTRB     <= '0;
            PPROT     <= '0;
        end else begin
            state     <= next_state;
            HREADYOUT <= (next_state == ST_IDLE) || (next_state == ST_DONE) ||
                         (next_state == ST_ERR2);
            HRESP     <= (next_state == ST_ERR1) || (next_state == ST_ERR2);
            PENABLE   <= (next_state == ST_ACCESS);
            case (next_state)
                ST_SETUP:  PSEL <= psel_d;
                ST_ACCESS: PSEL <= PSEL;
                default:   PSEL <= '0;
            endcase
            if (accept) begin
                PADDR  <= {HADDR[15:2], 2'b00};
                PWRITE <= HWRITE;
                PSTRB  <= HWRITE ? strb_of(HSIZE, HADDR[1:0]) : 4'b0000;
                PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
            end
            if ((state == ST_ACCESS) && sel_ready && !sel_err) begin
                HRDATA <= sel_rdata;
            end
        end
    end

    // The AHB master holds HWDATA while HREADYOUT is low, so it can pass straight through
    assign PWDATA = ((state == ST_SETUP) || (state == ST_ACCESS)) ? HWDATA : 32'h0;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb/tb_ahb_apb_bridge.sv - directed self-checking bench for ahb_apb_bridge (8 slots, timeout 4)
module tb_ahb_apb_bridge;

    localparam int N = 8;

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic             HSEL;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [3:0]       HPROT;
    logic [31:0]      HADDR;
    logic [31:0]      HWDATA;
    logic             HREADY;
    logic             HREADYOUT;
    logic             HRESP;
    logic [31:0]      HRDATA;
    logic [N-1:0]     PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [15:0]      PADDR;
    logic [31:0]      PWDATA;
    logic [3:0]       PSTRB;
    logic [2:0]       PPROT;
    logic [32*N-1:0]  PRDATA;
    logic [N-1:0]     PREADY;
    logic [N-1:0]     PSLVERR;

    int checks   = 0;
    int failures = 0;
    int waits;
    int acc;
    logic [N-1:0] psel_or;

    always #5 HCLK = ~HCLK;

    assign HREADY = HREADYOUT;

    ahb_apb_bridge #(
        .APB_SLAVES (N),
        .TIMEOUT    (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HPROT     (HPROT),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic start(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                         input logic [3:0] prot);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HSIZE = size; HADDR = addr; HPROT = prot;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    // APB slave model: PREADY held low for 'delay' ACCESS cycles, then high
    task automatic run_data(input int delay, output int w, output int a, output logic [N-1:0] p);
        w = 0; a = 0; p = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge HCLK);
            if (HREADYOUT) break;
            w++;
            p |= PSEL;
            if (PENABLE) a++;
            PREADY = (PENABLE && a > delay) ? '1 : '0;
        end
    endtask

    task automatic err_seq(input string tag);
        @(negedge HCLK);
        chk({tag, "_err1_ready"}, HREADYOUT, 1'b0);
        chk({tag, "_err1_resp"},  HRESP,     1'b1);
        chk({tag, "_err1_psel"},  PSEL,      '0);
        @(negedge HCLK);
        chk({tag, "_err2_ready"}, HREADYOUT, 1'b1);
        chk({tag, "_err2_resp"},  HRESP,     1'b1);
        chk({tag, "_err2_psel"},  PSEL,      '0);
        @(negedge HCLK);
        chk({tag, "_idle_resp"},  HRESP,     1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
        HPROT = 4'd0; HADDR = 32'd0; HWDATA = 32'd0;
        PREADY = '0; PSLVERR = '0; PRDATA = '0;
        PRDATA[1*32 +: 32] = 32'h0BAD0BAD;
        PRDATA[2*32 +: 32] = 32'h12345678;
        PRDATA[3*32 +: 32] = 32'hAAAA5555;
        repeat (2) @(negedge HCLK);
        chk("rst_hreadyout", HREADYOUT, 1'b1);
        chk("rst_hresp",     HRESP,     1'b0);
        chk("rst_hrdata",    HRDATA,    32'h0);
        chk("rst_psel",      PSEL,      8'h00);
        chk("rst_penable",   PENABLE,   1'b0);
        chk("rst_pwrite",    PWRITE,    1'b0);
        chk("rst_paddr",     PADDR,     16'h0);
        chk("rst_pstrb",     PSTRB,     4'h0);
        chk("rst_pprot",     PPROT,     3'b000);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // zero-wait word write to slot 3
        start(1'b1, 3'd2, 32'h0000_3004, 4'b0011);
        HWDATA = 32'hDEADBEEF; PREADY = '1;
        @(negedge HCLK);
        chk("wr_setup_psel",    PSEL,      8'h08);
        chk("wr_setup_penable", PENABLE,   1'b0);
        chk("wr_setup_ready",   HREADYOUT, 1'b0);
        chk("wr_paddr",         PADDR,     16'h3004);
        chk("wr_pstrb",         PSTRB,     4'hF);
        chk("wr_pwdata",        PWDATA,    32'hDEADBEEF);
        chk("wr_pwrite",        PWRITE,    1'b1);
        chk("wr_pprot",         PPROT,     3'b001);
        @(negedge HCLK);
        chk("wr_access_penable", PENABLE,   1'b1);
        chk("wr_access_ready",   HREADYOUT, 1'b0);
        @(negedge HCLK);
        chk("wr_done_ready", HREADYOUT, 1'b1);
        chk("wr_done_resp",  HRESP,     1'b0);
        chk("wr_done_psel",  PSEL,      8'h00);

        // read of slot 2 with three APB wait cycles
        PREADY = '0;
        start(1'b0, 3'd2, 32'h0000_2010, 4'b0000);
        run_data(3, waits, acc, psel_or);
        chk("rd_waits",  waits,   5);
        chk("rd_access", acc,     4);
        chk("rd_resp",   HRESP,   1'b0);
        chk("rd_hrdata", HRDATA,  32'h12345678);
        chk("rd_psel",   psel_or, 8'h04);
        chk("rd_pstrb",  PSTRB,   4'h0);
        chk("rd_pprot",  PPROT,   3'b100);

        // PSLVERR on slot 2: error response, HRDATA keeps the earlier value
        PRDATA[2*32 +: 32] = 32'h5A5A5A5A; PSLVERR = '1;
        start(1'b0, 3'd2, 32'h0000_2000, 4'b0000);
        run_data(0, waits, acc, psel_or);
        chk("slverr_waits",  waits,  3);
        chk("slverr_access", acc,    1);
        chk("slverr_resp",   HRESP,  1'b1);
        chk("slverr_hrdata", HRDATA, 32'h12345678);
        PSLVERR = '0; PRDATA[2*32 +: 32] = 32'h12345678;

        // halfword and byte write strobes
        PREADY = '0;
        start(1'b1, 3'd1, 32'h0000_1002, 4'b0010);
        HWDATA = 32'hBEEF0000;
        @(negedge HCLK);
        chk("hw_psel",   PSEL,   8'h02);
        chk("hw_pstrb",  PSTRB,  4'b1100);
        chk("hw_pwrite", PWRITE, 1'b1);
        chk("hw_pprot",  PPROT,  3'b101);
        chk("hw_paddr",  PADDR,  16'h1000);
        run_data(0, waits, acc, psel_or);
        chk("hw_waits", waits, 1);
        chk("hw_resp",  HRESP, 1'b0);
        start(1'b1, 3'd0, 32'h0000_1003, 4'b0000);
        @(negedge HCLK);
        chk("byte_pstrb", PSTRB, 4'b1000);
        run_data(0, waits, acc, psel_or);
        chk("byte_waits", waits, 1);

        // unmapped slot and oversized transfer
        start(1'b0, 3'd2, 32'h0000_F000, 4'b0000);
        err_seq("unmapped");
        start(1'b1, 3'd3, 32'h0000_1000, 4'b0000);
        err_seq("badsize");

        // timeout after 4 ACCESS cycles with PREADY low
        start(1'b0, 3'd2, 32'h0000_3000, 4'b0000);
        run_data(100, waits, acc, psel_or);
        chk("tmo_waits",  waits,   6);
        chk("tmo_access", acc,     4);
        chk("tmo_resp",   HRESP,   1'b1);
        chk("tmo_psel",   psel_or, 8'h08);

        // back-to-back reads: second address held through the first data phase
        PREADY = '1;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h0000_3000;
        @(posedge HCLK); #1;
        HADDR = 32'h0000_2000;
        @(negedge HCLK);
        chk("b2b_setup1_psel",    PSEL,    8'h08);
        chk("b2b_setup1_penable", PENABLE, 1'b0);
        @(negedge HCLK);
        @(negedge HCLK);
        chk("b2b_done1_ready",  HREADYOUT, 1'b1);
        chk("b2b_done1_hrdata", HRDATA,    32'hAAAA5555);
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        chk("b2b_setup2_psel",    PSEL,      8'h04);
        chk("b2b_setup2_penable", PENABLE,   1'b0);
        chk("b2b_setup2_ready",   HREADYOUT, 1'b0);
        @(negedge HCLK);
        @(negedge HCLK);
        chk("b2b_done2_ready",  HREADYOUT, 1'b1);
        chk("b2b_done2_hrdata", HRDATA,    32'h12345678);

        // asynchronous reset in the middle of ACCESS
        PREADY = '0;
        start(1'b0, 3'd2, 32'h0000_2000, 4'b0000);
        @(negedge HCLK);
        @(negedge HCLK);
        chk("rstmid_access_penable", PENABLE, 1'b1);
        #1 HRESETn = 1'b0;
        #1;
        chk("rstmid_psel",    PSEL,      8'h00);
        chk("rstmid_penable", PENABLE,   1'b0);
        chk("rstmid_ready",   HREADYOUT, 1'b1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rstmid_idle_psel",  PSEL,      8'h00);
        chk("rstmid_idle_ready", HREADYOUT, 1'b1);
        start(1'b1, 3'd2, 32'h0000_3008, 4'b0000);
        HWDATA = 32'hCAFEF00D;
        run_data(0, waits, acc, psel_or);
        chk("post_rst_waits", waits, 2);
        chk("post_rst_resp",  HRESP, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
